freq_meter: RTL and testbench

Gated frequency counter for the scope datapath. Counts rising edges of an asynchronous input signal between consecutive one-cycle gate pulses from the upstream 1 s timer and publishes the per-window count as a frequency in Hz, with a single-cycle valid strobe. It sits directly downstream of the 1 s timer and feeds the display/readout logic.

---
 rtl/freq_meter.sv | 135 +++++++++++++
 tb/tb_freq_meter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of i_sig between 1 s gate pulses, reports Hz.
// Define FREQ_METER_AVG_EN to report a 4-window moving average instead of the raw window count.
module freq_meter #(
  parameter int P_CNT_W       = 32,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_gate_pulse,
  input  logic               i_sig,
  input  logic               i_en,
  output logic [P_CNT_W-1:0] o_freq,
  output logic               o_valid,
  output logic               o_ovf,
  output logic               o_busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_COUNT = 2'd2} state_t;

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W-1:0] CNT_ONE = 1;

  state_t                     state, state_nxt;
  logic                       close_win;
  logic [P_SYNC_STAGES-1:0]   sync_q;
  logic                       sig_dly, edge_q;
  logic [P_CNT_W-1:0]         cnt_q, win_cnt;
  logic                       sat_q, win_sat, at_max;

  // Edge is registered once more so the counter sees it P_SYNC_STAGES+1 cycles after sampling
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q  <= '0;
      sig_dly <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[P_SYNC_STAGES-2:0], i_sig};
      sig_dly <= sync_q[P_SYNC_STAGES-1];
      edge_q  <= sync_q[P_SYNC_STAGES-1] & ~sig_dly;
    end
  end

  assign at_max  = (cnt_q == CNT_MAX);
  assign win_cnt = (edge_q && !at_max) ? cnt_q + CNT_ONE : cnt_q;
  assign win_sat = sat_q | (edge_q & at_max);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    close_win = 1'b0;
    if (!i_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_ARM;
        S_ARM:   if (i_gate_pulse) state_nxt = S_COUNT;
        S_COUNT: close_win = i_gate_pulse;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (!i_en || state != S_COUNT || close_win) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= win_cnt;
      sat_q <= win_sat;
    end
  end

  assign o_busy = (state != S_IDLE);

`ifdef FREQ_METER_AVG_EN
  logic [P_CNT_W-1:0] hist_cnt [3];
  logic [2:0]         hist_sat;
  logic [1:0]         n_win;
  logic [P_CNT_W+1:0] sum;

  assign sum = {2'b00, win_cnt} + {2'b00, hist_cnt[0]} + {2'b00, hist_cnt[1]} + {2'b00, hist_cnt[2]};

  // History only survives while we stay in S_COUNT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_freq   <= '0;
      o_valid  <= 1'b0;
      o_ovf    <= 1'b0;
      hist_cnt <= '{default: '0};
      hist_sat <= '0;
      n_win    <= '0;
    end else begin
      o_valid <= 1'b0;
      if (state_nxt != S_COUNT) begin
        hist_cnt <= '{default: '0};
        hist_sat <= '0;
        n_win    <= '0;
      end else if (close_win) begin
        hist_cnt[2] <= hist_cnt[1];
        hist_cnt[1] <= hist_cnt[0];
        hist_cnt[0] <= win_cnt;
        hist_sat    <= {hist_sat[1:0], win_sat};
        if (n_win != 2'd3) n_win <= n_win + 2'd1;
        if (n_win == 2'd3) begin
          o_valid <= 1'b1;
          o_freq  <= sum[P_CNT_W+1:2];
          o_ovf   <= win_sat | (|hist_sat);
        end
      end
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_freq  <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_valid <= close_win;
      if (close_win) begin
        o_freq <= win_cnt;
        o_ovf  <= win_sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (32-bit and 4-bit counters) share stimulus and are checked every cycle.
module tb_freq_meter;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic        i_clk = 1'b0, i_rst = 1'b1, i_gate_pulse = 1'b0, i_sig = 1'b0, i_en = 1'b0;
  logic [31:0] f0;
  logic [3:0]  f1;
  logic        v0, v1, ov0, ov1, b0, b1;

  always #5 i_clk = ~i_clk;

  freq_meter #(.P_CNT_W(32), .P_SYNC_STAGES(SYNC)) u_dut32 (
    .i_clk(i_clk), .i_rst(i_rst), .i_gate_pulse(i_gate_pulse), .i_sig(i_sig), .i_en(i_en),
    .o_freq(f0), .o_valid(v0), .o_ovf(ov0), .o_busy(b0));

  freq_meter #(.P_CNT_W(4), .P_SYNC_STAGES(SYNC)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_gate_pulse(i_gate_pulse), .i_sig(i_sig), .i_en(i_en),
    .o_freq(f1), .o_valid(v1), .o_ovf(ov1), .o_busy(b1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: window counts from sampled-input history, one entry per instance
  longint m_max [2] = '{64'hFFFF_FFFF, 64'd15};
  int     m_mode[2] = '{0, 0};   // 0 idle, 1 waiting for first gate, 2 counting
  longint m_cnt [2] = '{0, 0};
  bit     m_sat [2] = '{0, 0};
  longint m_freq[2] = '{0, 0};
  bit     m_ovf [2] = '{0, 0};
  bit     m_valid[2] = '{0, 0};
  bit     hist[LAT+2];
`ifdef FREQ_METER_AVG_EN
  longint wq[2][$];
  bit     sq[2][$];
`endif

  task automatic report(input int i, input longint tot, input bit f);
`ifdef FREQ_METER_AVG_EN
    longint s;
    bit     o;
    wq[i].push_back(tot);
    sq[i].push_back(f);
    if (wq[i].size() > 4) begin
      void'(wq[i].pop_front());
      void'(sq[i].pop_front());
    end
    if (wq[i].size() == 4) begin
      s = 0;
      o = 0;
      for (int k = 0; k < 4; k++) begin
        s += wq[i][k];
        o |= sq[i][k];
      end
      m_freq[i]  = s / 4;
      m_ovf[i]   = o;
      m_valid[i] = 1;
    end
`else
    m_freq[i]  = tot;
    m_ovf[i]   = f;
    m_valid[i] = 1;
`endif
  endtask

  task automatic model_step(input int i, input bit e);
    longint tot;
    bit     s;
    m_valid[i] = 0;
    if (!i_en) begin
      m_mode[i] = 0;
      m_cnt[i]  = 0;
      m_sat[i]  = 0;
`ifdef FREQ_METER_AVG_EN
      wq[i].delete();
      sq[i].delete();
`endif
    end else if (m_mode[i] == 0) begin
      m_mode[i] = 1;
    end else if (m_mode[i] == 1) begin
      if (i_gate_pulse) begin
        m_mode[i] = 2;
        m_cnt[i]  = 0;
        m_sat[i]  = 0;
      end
    end else begin
      tot = m_cnt[i] + longint'(e);
      s   = 0;
      if (tot > m_max[i]) begin
        tot = m_max[i];
        s   = 1;
      end
      if (i_gate_pulse) begin
        report(i, tot, m_sat[i] | s);
        m_cnt[i] = 0;
        m_sat[i] = 0;
      end else begin
        m_cnt[i] = tot;
        m_sat[i] = m_sat[i] | s;
      end
    end
  endtask

  always @(posedge i_clk) begin
    bit e;
    if (i_rst) begin
      foreach (hist[j]) hist[j] = 0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
        m_freq[i] = 0; m_ovf[i] = 0; m_valid[i] = 0;
`ifdef FREQ_METER_AVG_EN
        wq[i].delete();
        sq[i].delete();
`endif
      end
    end else begin
      for (int j = LAT + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = i_sig;
      e = hist[LAT] & ~hist[LAT+1];
      for (int i = 0; i < 2; i++) model_step(i, e);
    end
    #1;
    chk("freq32",  f0,  m_freq[0]);
    chk("valid32", v0,  m_valid[0]);
    chk("ovf32",   ov0, m_ovf[0]);
    chk("busy32",  b0,  m_mode[0] != 0);
    chk("freq4",   f1,  m_freq[1]);
    chk("valid4",  v1,  m_valid[1]);
    chk("ovf4",    ov1, m_ovf[1]);
    chk("busy4",   b1,  m_mode[1] != 0);
  end

  task automatic step(input bit g, input bit s);
    @(negedge i_clk);
    i_gate_pulse = g;
    i_sig        = s;
  endtask

  // One window of len cycles closed by a gate on the last cycle; pulses every sper cycles (nmax of them),
  // plus optionally one pulse timed so its edge is counted in the gate cycle.
  // mode: 0 no literal check, 1 expect no report, 2 expect report e0/e1 (ovf of 4-bit instance eo1)
  task automatic window(input int len, input int sper, input int nmax, input bit extra,
                        input int mode, input longint e0, input longint e1, input bit eo1);
    bit s;
    for (int c = 0; c < len; c++) begin
      s = (sper > 0 && (c % sper) == 0 && (c / sper) < nmax) || (extra && c == len - 1 - LAT);
      step(c == len - 1, s);
    end
    @(posedge i_clk);
    #1;
    if (mode == 1) begin
      chk("lit_no_report32", v0, 0);
      chk("lit_no_report4",  v1, 0);
    end
`ifndef FREQ_METER_AVG_EN
    if (mode == 2) begin
      chk("lit_valid32", v0,  1);
      chk("lit_freq32",  f0,  e0);
      chk("lit_ovf32",   ov0, 0);
      chk("lit_valid4",  v1,  1);
      chk("lit_freq4",   f1,  e1);
      chk("lit_ovf4",    ov1, eo1);
    end
`endif
  endtask

  initial begin
    #2;
    chk("rst_freq",  f0,  0);
    chk("rst_valid", v0,  0);
    chk("rst_ovf",   ov0, 0);
    chk("rst_busy",  b0,  0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    i_en  = 1'b1;
    @(posedge i_clk);
    #1;
    chk("busy_after_en", b0, 1);

    // 100 Hz-equivalent: arm window, then two reporting windows
    window(1000, 10, 100, 0, 1, 0, 0, 0);
    window(1000, 10, 100, 0, 2, 100, 15, 1);
    window(1000, 10, 100, 0, 2, 100, 15, 1);
    // saturation of the 4-bit counter, then recovery
    window(100, 4, 20, 0, 2, 20, 15, 1);
    window(100, 4, 5, 0, 2, 5, 5, 0);
    // edge in the gate cycle belongs to the closing window
    window(50, 10, 3, 1, 2, 4, 4, 0);
    window(50, 10, 2, 0, 2, 2, 2, 0);
    // back-to-back gates, then max rate i_clk/2
    repeat (4) window(2, 0, 0, 0, 2, 0, 0, 0);
    window(50, 2, 20, 0, 2, 20, 15, 1);

    // enable dropped mid-window
    for (int c = 0; c < 300; c++) step(0, (c % 10) == 0);
    i_en = 1'b0;
    repeat (5) step(0, 0);
    @(posedge i_clk);
    #1;
    chk("en_drop_valid", v0, 0);
    chk("en_drop_hold",  f0, 20);
    chk("en_drop_hold4", f1, 15);
    chk("en_drop_busy",  b0, 0);
    i_en = 1'b1;
    window(1000, 10, 100, 0, 1, 0, 0, 0);
    window(1000, 10, 100, 0, 2, 100, 15, 1);

    // enable low wins over a simultaneous gate
    for (int c = 0; c < 100; c++) step(0, (c % 10) == 0);
    @(negedge i_clk);
    i_en = 1'b0;
    i_gate_pulse = 1'b1;
    i_sig = 1'b0;
    @(posedge i_clk);
    #1;
    chk("en_gate_valid", v0, 0);
    chk("en_gate_hold",  f0, 100);
    @(negedge i_clk);
    i_gate_pulse = 1'b0;
    i_en = 1'b1;

    // asynchronous reset mid-window
    window(1000, 10, 100, 0, 1, 0, 0, 0);
    for (int c = 0; c < 300; c++) step(0, (c % 10) == 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    i_sig = 1'b0;
    #1;
    chk("arst_freq", f0,  0);
    chk("arst_ovf4", ov1, 0);
    chk("arst_busy", b0,  0);
    chk("arst_freq4", f1, 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    window(1000, 10, 100, 0, 1, 0, 0, 0);
    window(1000, 10, 100, 0, 2, 100, 15, 1);
`ifdef FREQ_METER_AVG_EN
    window(1000, 10, 100, 0, 0, 0, 0, 0);
    window(1000, 10, 100, 0, 0, 0, 0, 0);
    window(1000, 9, 104, 0, 0, 0, 0, 0);
    chk("avg_valid", v0, 1);
    chk("avg_freq",  f0, 101);
`endif

    step(0, 0);
    repeat (5) @(posedge i_clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
